scroll_controller: RTL and testbench

SCROLL_CONTROLLER -- requirements
Module: scroll_controller

---
 rtl/scroll_controller.sv | 124 ++++++++++++
 tb/tb_scroll_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_controller.sv
// Side-scrolling controller: loads the first visible level columns after reset,
// then fine-scrolls on frame ticks and streams a new ROM column each 40-pixel wrap.
module scroll_controller #(
    parameter logic [9:0] SCROLL_THRESHOLD = 10'd320,
    parameter logic [5:0] SCROLL_STEP      = 6'd2,
    parameter logic [7:0] LEVEL_COLS       = 8'd200,
    parameter logic [3:0] VISIBLE_COLS     = 4'd10
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic [9:0]  Mario_X_Pos,
    input  logic        Mario_moving_right,
    output logic [7:0]  rom_addr,
    input  logic [29:0] rom_data,
    output logic [29:0] new_block_id,
    output logic        Shift,
    output logic [5:0]  scroll_offset,
    output logic        hold_mario,
    output logic        busy,
    output logic        level_end,
    output logic [7:0]  col_index
);

    typedef enum logic [2:0] {
        INIT_FETCH, INIT_WAIT, INIT_SHIFT, IDLE, FETCH, WAIT, SHIFT
    } state_t;

    state_t      state_q;
    logic [7:0]  colIndex_q;
    logic [3:0]  initCount_q;
    logic [5:0]  scrollOffset_q;
    logic [29:0] blockId_q;
    logic        shift_q;
    logic        hold_q;
    logic        levelEnd_q;

    logic        scrollReq_d;
    logic [6:0]  offsetSum_d;
    logic        offsetWrap_d;
    logic        lastCol_d;
    logic [4:0]  initNext_d;

    always_comb begin
        scrollReq_d  = frame_tick && (Mario_X_Pos > SCROLL_THRESHOLD)
                       && Mario_moving_right && !levelEnd_q;
        offsetSum_d  = {1'b0, scrollOffset_q} + {1'b0, SCROLL_STEP};
        offsetWrap_d = (offsetSum_d >= 7'd40);
        lastCol_d    = ((colIndex_q + 8'd1) == LEVEL_COLS);
        initNext_d   = {1'b0, initCount_q} + 5'd1;
    end

    // Ticks are only sampled in IDLE, so a tick during a column fetch is dropped.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q        <= INIT_FETCH;
            colIndex_q     <= 8'd0;
            initCount_q    <= 4'd0;
            scrollOffset_q <= 6'd0;
            blockId_q      <= 30'd0;
            shift_q        <= 1'b0;
            hold_q         <= 1'b0;
            levelEnd_q     <= 1'b0;
        end else begin
            shift_q <= 1'b0;
            hold_q  <= 1'b0;
            case (state_q)
                INIT_FETCH: state_q <= INIT_WAIT;
                INIT_WAIT: begin
                    blockId_q <= rom_data;
                    shift_q   <= 1'b1;
                    state_q   <= INIT_SHIFT;
                end
                INIT_SHIFT: begin
                    colIndex_q  <= colIndex_q + 8'd1;
                    initCount_q <= initCount_q + 4'd1;
                    if (lastCol_d) begin
                        levelEnd_q <= 1'b1;
                        state_q    <= IDLE;
                    end else if (initNext_d < {1'b0, VISIBLE_COLS}) begin
                        state_q <= INIT_FETCH;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (scrollReq_d) begin
                        hold_q <= 1'b1;
                        if (offsetWrap_d) begin
                            scrollOffset_q <= 6'd0;
                            state_q        <= FETCH;
                        end else begin
                            scrollOffset_q <= offsetSum_d[5:0];
                        end
                    end
                end
                FETCH: state_q <= WAIT;
                WAIT: begin
                    blockId_q <= rom_data;
                    shift_q   <= 1'b1;
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    colIndex_q <= colIndex_q + 8'd1;
                    if (lastCol_d) begin
                        levelEnd_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= INIT_FETCH;
            endcase
        end
    end

    assign rom_addr      = colIndex_q;
    assign col_index     = colIndex_q;
    assign new_block_id  = blockId_q;
    assign Shift         = shift_q;
    assign scroll_offset = scrollOffset_q;
    assign hold_mario    = hold_q;
    assign level_end     = levelEnd_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_scroll_controller.sv
// Bench for scroll_controller: a full-length level and a 12-column level run side by
// side on shared stimulus, each compared against a per-frame arithmetic model.
module tb_scroll_controller;

    logic        Clk;
    logic        Reset_n;
    logic        frame_tick;
    logic [9:0]  Mario_X_Pos;
    logic        Mario_moving_right;

    logic [1:0][7:0]  addrO;
    logic [1:0][29:0] romQ;
    logic [1:0][29:0] blockO;
    logic [1:0]       shiftO;
    logic [1:0][5:0]  offO;
    logic [1:0]       holdO;
    logic [1:0]       busyO;
    logic [1:0]       endO;
    logic [1:0][7:0]  colO;

    int total = 0;
    int bad   = 0;

    // Model state per instance: 0 = 200-column level, 1 = 12-column level.
    int mOff[2];
    int mCol[2];
    bit mEnd[2];
    int levelCols[2] = '{200, 12};

    scroll_controller dutMain (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .Mario_X_Pos(Mario_X_Pos), .Mario_moving_right(Mario_moving_right),
        .rom_addr(addrO[0]), .rom_data(romQ[0]), .new_block_id(blockO[0]),
        .Shift(shiftO[0]), .scroll_offset(offO[0]), .hold_mario(holdO[0]),
        .busy(busyO[0]), .level_end(endO[0]), .col_index(colO[0])
    );

    scroll_controller #(.LEVEL_COLS(8'd12)) dutSmall (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .Mario_X_Pos(Mario_X_Pos), .Mario_moving_right(Mario_moving_right),
        .rom_addr(addrO[1]), .rom_data(romQ[1]), .new_block_id(blockO[1]),
        .Shift(shiftO[1]), .scroll_offset(offO[1]), .hold_mario(holdO[1]),
        .busy(busyO[1]), .level_end(endO[1]), .col_index(colO[1])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [29:0] romCol(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {b[5:0], b, b, b};
    endfunction

    // Synchronous level ROM: data appears one cycle after the address.
    always @(posedge Clk) begin
        romQ[0] <= romCol(int'(addrO[0]));
        romQ[1] <= romCol(int'(addrO[1]));
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Watches the power-up column load; column count equals Shift pulses seen so far.
    task automatic checkInit();
        int  pulses[2];
        bit  prev[2];
        int  cyc;
        pulses = '{0, 0};
        prev   = '{0, 0};
        cyc    = 0;
        while (busyO != 2'b00 && cyc < 200) begin
            tick();
            cyc++;
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("initCol%0d", d), 32'(colO[d]), 32'(pulses[d]));
                checkOutput($sformatf("initAddr%0d", d), 32'(addrO[d]), 32'(pulses[d]));
                if (shiftO[d]) begin
                    checkOutput($sformatf("initGap%0d", d), 32'(prev[d]), 32'd0);
                    checkOutput($sformatf("initBlock%0d", d), 32'(blockO[d]), 32'(romCol(pulses[d])));
                    pulses[d]++;
                end
                prev[d] = shiftO[d];
            end
        end
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("initBusy%0d", d), 32'(busyO[d]), 32'd0);
            checkOutput($sformatf("initPulses%0d", d), 32'(pulses[d]), 32'd10);
            checkOutput($sformatf("initColEnd%0d", d), 32'(colO[d]), 32'd10);
            checkOutput($sformatf("initOff%0d", d), 32'(offO[d]), 32'd0);
            checkOutput($sformatf("initEnd%0d", d), 32'(endO[d]), 32'd0);
            mCol[d] = 10;
            mOff[d] = 0;
            mEnd[d] = 1'b0;
        end
    endtask

    // One frame tick followed by four checked cycles covering a full column fetch.
    task automatic applyStimulus(input logic [9:0] x, input logic dir, input logic tickInWait);
        bit scr[2];
        bit wrp[2];
        int fetchCol[2];
        Mario_X_Pos        = x;
        Mario_moving_right = dir;
        frame_tick         = 1'b1;
        for (int d = 0; d < 2; d++) begin
            scr[d]      = (x > 10'd320) && dir && !mEnd[d];
            wrp[d]      = 1'b0;
            fetchCol[d] = mCol[d];
            if (scr[d]) begin
                mOff[d] = (mOff[d] + 2) % 40;
                wrp[d]  = (mOff[d] == 0);
            end
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            frame_tick = (c == 2) ? tickInWait : 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (c == 4 && wrp[d]) begin
                    mCol[d]++;
                    if (mCol[d] == levelCols[d]) mEnd[d] = 1'b1;
                end
                checkOutput($sformatf("hold%0d_c%0d", d, c), 32'(holdO[d]), 32'(c == 1 && scr[d]));
                checkOutput($sformatf("shift%0d_c%0d", d, c), 32'(shiftO[d]), 32'(c == 3 && wrp[d]));
                checkOutput($sformatf("offset%0d_c%0d", d, c), 32'(offO[d]), 32'(mOff[d]));
                checkOutput($sformatf("col%0d_c%0d", d, c), 32'(colO[d]), 32'(mCol[d]));
                checkOutput($sformatf("addr%0d_c%0d", d, c), 32'(addrO[d]), 32'(mCol[d]));
                checkOutput($sformatf("busy%0d_c%0d", d, c), 32'(busyO[d]), 32'(wrp[d] && c < 4));
                checkOutput($sformatf("end%0d_c%0d", d, c), 32'(endO[d]), 32'(mEnd[d]));
                if (c == 3 && wrp[d])
                    checkOutput($sformatf("block%0d", d), 32'(blockO[d]), 32'(romCol(fetchCol[d])));
            end
        end
    endtask

    initial begin
        int guard;
        Reset_n            = 1'b0;
        frame_tick         = 1'b0;
        Mario_X_Pos        = 10'd0;
        Mario_moving_right = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rstCol%0d", d), 32'(colO[d]), 32'd0);
            checkOutput($sformatf("rstShift%0d", d), 32'(shiftO[d]), 32'd0);
            checkOutput($sformatf("rstBusy%0d", d), 32'(busyO[d]), 32'd1);
            checkOutput($sformatf("rstHold%0d", d), 32'(holdO[d]), 32'd0);
            checkOutput($sformatf("rstOff%0d", d), 32'(offO[d]), 32'd0);
            checkOutput($sformatf("rstEnd%0d", d), 32'(endO[d]), 32'd0);
            checkOutput($sformatf("rstBlock%0d", d), 32'(blockO[d]), 32'd0);
        end
        Reset_n = 1'b1;
        $display("[TB] power-up load");
        checkInit();

        $display("[TB] threshold and direction boundaries");
        applyStimulus(10'd320, 1'b1, 1'b0);
        applyStimulus(10'd330, 1'b0, 1'b0);
        applyStimulus(10'd1023, 1'b0, 1'b0);

        $display("[TB] twenty scrolling frames, last one with a tick during WAIT");
        for (int i = 1; i <= 20; i++)
            applyStimulus(10'd330, 1'b1, (i == 20));

        $display("[TB] randomized frames");
        for (int i = 0; i < 60; i++) begin
            logic [9:0] x;
            logic       dir;
            x   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 320)) : 10'($urandom_range(321, 1023));
            dir = ($urandom_range(0, 4) != 0);
            applyStimulus(x, dir, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("[TB] drive short level to its end");
        guard = 0;
        while (!mEnd[1] && guard < 60) begin
            applyStimulus(10'd330, 1'b1, 1'b0);
            guard++;
        end
        checkOutput("smallLevelEnd", 32'(endO[1]), 32'd1);
        for (int i = 0; i < 3; i++)
            applyStimulus(10'd400, 1'b1, 1'b0);

        $display("[TB] reset during WAIT");
        guard = 0;
        while (((mOff[0] + 2) % 40) != 0 && guard < 25) begin
            applyStimulus(10'd330, 1'b1, 1'b0);
            guard++;
        end
        Mario_X_Pos        = 10'd330;
        Mario_moving_right = 1'b1;
        frame_tick         = 1'b1;
        tick();
        frame_tick = 1'b0;
        checkOutput("preRstBusy", 32'(busyO[0]), 32'd1);
        tick();
        Reset_n = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("midRstShift%0d", d), 32'(shiftO[d]), 32'd0);
            checkOutput($sformatf("midRstCol%0d", d), 32'(colO[d]), 32'd0);
            checkOutput($sformatf("midRstBusy%0d", d), 32'(busyO[d]), 32'd1);
            checkOutput($sformatf("midRstEnd%0d", d), 32'(endO[d]), 32'd0);
        end
        Reset_n = 1'b1;
        checkInit();

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
